// File: rtl/cpu_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 size codes, FSM states
// and completion status codes.
package cpu_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_t;

    // Encodings with no RV32I meaning; stores have no unsigned variants.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// Combinational datapath of the LSU: request legality/alignment check,
// store lane steering with byte enables, and load lane extraction/extension.
module lsu_align
    import cpu_lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output err_t        chk_err,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic        misalign;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Classify the incoming request; illegal encodings win over misalignment.
    always_comb begin
        misalign = 1'b0;
        if (funct3[1:0] == 2'b01)      misalign = addr_lo[0];
        else if (funct3[1:0] == 2'b10) misalign = (addr_lo != 2'b00);
        chk_err = ERR_OK;
        if (f3_illegal(we, funct3)) chk_err = ERR_ILLEGAL;
        else if (misalign)          chk_err = ERR_MISALIGN;
    end

    // Replicate store data across lanes; loads drive zero write data.
    always_comb begin
        bus_be    = 4'b1111;
        bus_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                bus_be    = 4'b0001 << addr_lo;
                bus_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                bus_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                bus_wdata = {2{wdata[15:0]}};
            end
            default: begin
                bus_be    = 4'b1111;
                bus_wdata = wdata;
            end
        endcase
        if (!we) bus_wdata = '0;
    end

    // Pick the addressed lane(s) of the returned word and extend.
    always_comb begin
        case (ld_addr_lo)
            2'b00:   ld_byte = ld_word[7:0];
            2'b01:   ld_byte = ld_word[15:8];
            2'b10:   ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_W:    ld_data = ld_word;
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/cpu_lsu.sv
// Handshaked load/store unit: accepts one core request at a time, runs a
// ready/valid bus cycle with a wait-state timeout, and reports completion.
//
//  state | meaning
//  IDLE  | no transaction, accepting requests
//  REQ   | bus cycle outstanding, busReq high, waiting for busReady
//  RESP  | completion cycle (done pulse); still accepting requests
module cpu_lsu
    import cpu_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [1:0]        err,
    output logic              busReq,
    output logic              busWe,
    output logic [ADDR_W-1:0] busAddr,
    output logic [31:0]       busWData,
    output logic [3:0]        busBe,
    input  logic              busReady,
    input  logic [31:0]       busRData
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state;
    logic [2:0]       reg_f3;
    logic [1:0]       reg_lo;
    logic [CNT_W-1:0] wait_cnt;

    err_t             chk_err;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_data;
    logic             timeout_hit;

    lsu_align u_align (
        .we         (we),
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .chk_err    (chk_err),
        .bus_be     (st_be),
        .bus_wdata  (st_wdata),
        .ld_funct3  (reg_f3),
        .ld_addr_lo (reg_lo),
        .ld_word    (busRData),
        .ld_data    (ld_data)
    );

    assign busy        = (state == REQ);
    // A zero timeout disables the abort path entirely.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);

    // Transaction FSM with registered bus fields, status and load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            rdata    <= '0;
            err      <= ERR_OK;
            busReq   <= 1'b0;
            busWe    <= 1'b0;
            busAddr  <= '0;
            busWData <= '0;
            busBe    <= '0;
            reg_f3   <= '0;
            reg_lo   <= '0;
            wait_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (req) begin
                        if (chk_err == ERR_OK) begin
                            state    <= REQ;
                            busReq   <= 1'b1;
                            busWe    <= we;
                            busAddr  <= {addr[ADDR_W-1:2], 2'b00};
                            busWData <= st_wdata;
                            busBe    <= st_be;
                            reg_f3   <= funct3;
                            reg_lo   <= addr[1:0];
                            wait_cnt <= '0;
                        end else begin
                            // Rejected access completes without touching the bus.
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= chk_err;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    // busReady wins over a timeout landing in the same cycle.
                    if (busReady) begin
                        state  <= RESP;
                        busReq <= 1'b0;
                        done   <= 1'b1;
                        err    <= ERR_OK;
                        if (!busWe) rdata <= ld_data;
                    end else if (timeout_hit) begin
                        state  <= RESP;
                        busReq <= 1'b0;
                        done   <= 1'b1;
                        err    <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_lsu.sv
module tb_cpu_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [3:0]  busBe;
    logic        busReady;
    logic [31:0] busRData;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    cpu_lsu #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .busReq   (busReq),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .busWData (busWData),
        .busBe    (busBe),
        .busReady (busReady),
        .busRData (busRData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] r, input logic [1:0] e,
                            input int lat);
        exp_t x;
        x.tag = tag; x.rdata = r; x.err = e; x.lat = lat;
        sb.push_back(x);
    endtask

    // Compare a completion against the oldest scoreboard entry.
    task automatic pop_cmp(input int cyc);
        exp_t x;
        if (sb.size() == 0) begin
            chk("done_without_expectation", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            chk({x.tag, "_rdata"}, rdata, x.rdata);
            chk({x.tag, "_err"}, {30'd0, err}, {30'd0, x.err});
            chk({x.tag, "_latency"}, cyc, x.lat);
        end
    endtask

    // Issue one access and act as the slave: busReady after 'waits' wait states.
    task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rword,
                       input int waits, input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input logic [31:0] e_rdata,
                       input logic [1:0] e_err, input int e_lat, input int e_buscyc);
        int  cyc = 0;
        int  wc = 0;
        int  bcnt = 0;
        bit  seen = 1'b0;
        @(negedge clk);
        drive_req(w, f3, a, d);
        push_exp(tag, e_rdata, e_err, e_lat);
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            req = 1'b0;
            if (busReq) begin
                bcnt++;
                chk({tag, "_busAddr"}, busAddr, e_addr);
                chk({tag, "_busBe"}, {28'd0, busBe}, {28'd0, e_be});
                chk({tag, "_busWData"}, busWData, e_wd);
                chk({tag, "_busWe"}, {31'd0, busWe}, {31'd0, w});
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                busRData = rword;
                busReady = (wc == waits);
                wc++;
            end else begin
                busReady = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                pop_cmp(cyc);
            end
        end
        busReady = 1'b0;
        chk({tag, "_completed"}, {31'd0, seen}, 32'd1);
        chk({tag, "_busReq_cycles"}, bcnt, e_buscyc);
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
        busReady = 1'b0; busRData = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busReq", {31'd0, busReq}, 32'd0);
        chk("rst_busWe", {31'd0, busWe}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busAddr", busAddr, 32'd0);
        chk("rst_busWData", busWData, 32'd0);
        chk("rst_busBe", {28'd0, busBe}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        reset = 1'b1;

        txn("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0,
            32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 2'b00, 2, 1);
        txn("lb_wait3", 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 3,
            32'h200, 4'b1000, 32'h0, 32'hFFFFFF80, 2'b00, 5, 4);
        txn("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 0,
            32'h200, 4'b1000, 32'h0, 32'h00000080, 2'b00, 2, 1);
        txn("sh", 1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 0,
            32'h10, 4'b1100, 32'hABCDABCD, 32'h00000080, 2'b00, 2, 1);
        txn("lh_misalign", 1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 0,
            32'h0, 4'b0000, 32'h0, 32'h00000080, 2'b01, 1, 0);
        txn("lw_misalign", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 0,
            32'h0, 4'b0000, 32'h0, 32'h00000080, 2'b01, 1, 0);
        txn("f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 0,
            32'h0, 4'b0000, 32'h0, 32'h00000080, 2'b11, 1, 0);
        txn("sbu_illegal", 1'b1, 3'b100, 32'h21, 32'h0, 32'h0, 0,
            32'h0, 4'b0000, 32'h0, 32'h00000080, 2'b11, 1, 0);
        txn("illegal_over_misalign", 1'b1, 3'b101, 32'h23, 32'h0, 32'h0, 0,
            32'h0, 4'b0000, 32'h0, 32'h00000080, 2'b11, 1, 0);
        txn("lw_timeout", 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 99,
            32'h300, 4'b1111, 32'h0, 32'h00000080, 2'b10, 5, 4);
        txn("lhu_hi", 1'b0, 3'b101, 32'h302, 32'h0, 32'hBEEF8001, 1,
            32'h300, 4'b1100, 32'h0, 32'h0000BEEF, 2'b00, 3, 2);
        txn("lh_lo", 1'b0, 3'b001, 32'h100, 32'h0, 32'h00008001, 0,
            32'h100, 4'b0011, 32'h0, 32'hFFFF8001, 2'b00, 2, 1);
        txn("sb_lane1", 1'b1, 3'b000, 32'h101, 32'h0000005A, 32'h0, 0,
            32'h100, 4'b0010, 32'h5A5A5A5A, 32'hFFFF8001, 2'b00, 2, 1);

        // Back-to-back zero-wait loads; a request raised while busy is dropped.
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h40, 32'h0);
        push_exp("b2b_first", 32'h11112222, 2'b00, 2);
        @(negedge clk);
        req = 1'b0;
        chk("b2b_c1_busReq", {31'd0, busReq}, 32'd1);
        chk("b2b_c1_busAddr", busAddr, 32'h40);
        busReady = 1'b1; busRData = 32'h11112222;
        @(negedge clk);
        chk("b2b_c2_busReq", {31'd0, busReq}, 32'd0);
        chk("b2b_c2_done", {31'd0, done}, 32'd1);
        if (done) pop_cmp(2);
        busReady = 1'b0;
        drive_req(1'b0, 3'b010, 32'h44, 32'h0);
        push_exp("b2b_second", 32'h33334444, 2'b00, 2);
        @(negedge clk);
        chk("b2b_c3_busReq", {31'd0, busReq}, 32'd1);
        chk("b2b_c3_busAddr", busAddr, 32'h44);
        drive_req(1'b0, 3'b010, 32'h80, 32'h0);
        busReady = 1'b1; busRData = 32'h33334444;
        @(negedge clk);
        req = 1'b0; busReady = 1'b0;
        chk("b2b_c4_done", {31'd0, done}, 32'd1);
        chk("b2b_c4_busReq", {31'd0, busReq}, 32'd0);
        if (done) pop_cmp(2);
        @(negedge clk);
        chk("ignored_req_busReq", {31'd0, busReq}, 32'd0);
        chk("ignored_req_busy", {31'd0, busy}, 32'd0);
        chk("ignored_req_done", {31'd0, done}, 32'd0);

        // Reset asserted during a wait state.
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h500, 32'h0);
        @(negedge clk);
        req = 1'b0;
        chk("rstmid_busReq_before", {31'd0, busReq}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_busReq", {31'd0, busReq}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        chk("rstmid_busAddr", busAddr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        txn("lw_after_reset", 1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, 0,
            32'h400, 4'b1111, 32'h0, 32'h12345678, 2'b00, 2, 1);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
